res_disp: RTL and testbench

Downstream display stage for the calculator datapath. It captures the 8-bit result {high nibble, low nibble} produced by the function units (max, etc.) on a load strobe. It converts the result to hex or decimal digits with a sequential shift-add-3 engine. It time-multiplexes the digits onto a 4-digit common-anode 7-segment display.

---
 rtl/res_disp.sv | 160 ++++++++++++++++
 tb/tb_res_disp.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/res_disp.sv
// Result display stage: captures an 8-bit result, converts it to hex or BCD digits
// with a one-bit-per-cycle shift-add-3 engine, and scans it onto a 4-digit common-anode display.
module res_disp #(
  parameter int SCAN_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] disp_high,
  input  logic [3:0] disp_low,
  input  logic       disp_load,
  input  logic       disp_dec,
  input  logic       disp_blank,
  output logic       disp_busy,
  output logic [6:0] disp_seg,
  output logic [3:0] disp_an
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_val;
  logic        r_dec;
  logic [11:0] r_bcd;
  logic [2:0]  r_bit;
  logic [3:0]  r_d2, r_d1, r_d0;
  logic        r_show_dec;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]  r_idx;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;

  logic        w_accept, w_done;
  logic        w_in_bit;
  logic [11:0] w_adj, w_bcd_nxt;
  logic [3:0]  w_digit;
  logic        w_blank;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24; 4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12; 4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00; 4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06; default: seg7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: if (disp_load) begin
        w_accept    = 1'b1;
        w_state_nxt = CONV;
      end
      CONV: if (r_bit == 3'd7) begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Captured value stays intact (hex digits need it); bits are picked MSB first by r_bit.
  always_comb begin
    w_in_bit = r_val[3'd7 - r_bit];
    w_adj    = r_bcd;
    for (int n = 0; n < 3; n++) begin
      if (r_bcd[n*4 +: 4] >= 4'd5) w_adj[n*4 +: 4] = r_bcd[n*4 +: 4] + 4'd3;
    end
    w_bcd_nxt = {w_adj[10:0], w_in_bit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_val      <= 8'h00;
      r_dec      <= 1'b0;
      r_bcd      <= 12'h000;
      r_bit      <= 3'd0;
      r_d2       <= 4'h0;
      r_d1       <= 4'h0;
      r_d0       <= 4'h0;
      r_show_dec <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_val <= {disp_high, disp_low};
        r_dec <= disp_dec;
        r_bcd <= 12'h000;
        r_bit <= 3'd0;
      end else if (r_state == CONV) begin
        r_bcd <= w_bcd_nxt;
        r_bit <= r_bit + 3'd1;
      end
      // Shown digits change only here, so a conversion never leaks partial results.
      if (w_done) begin
        r_show_dec <= r_dec;
        if (r_dec) begin
          r_d2 <= w_bcd_nxt[11:8];
          r_d1 <= w_bcd_nxt[7:4];
          r_d0 <= w_bcd_nxt[3:0];
        end else begin
          r_d2 <= 4'h0;
          r_d1 <= r_val[7:4];
          r_d0 <= r_val[3:0];
        end
      end
    end
  end

  always_comb begin
    w_digit = 4'h0;
    w_blank = 1'b1;
    case (r_idx)
      2'd0: begin
        w_digit = r_d0;
        w_blank = 1'b0;
      end
      2'd1: begin
        w_digit = r_d1;
        w_blank = r_show_dec ? (disp_blank && r_d2 == 4'h0 && r_d1 == 4'h0)
                             : (disp_blank && r_d1 == 4'h0);
      end
      2'd2: begin
        w_digit = r_d2;
        w_blank = r_show_dec ? (disp_blank && r_d2 == 4'h0) : 1'b1;
      end
      default: begin
        w_digit = 4'h0;
        w_blank = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
      r_an  <= 4'b1111;
      r_seg <= 7'h7F;
    end else begin
      if (r_cnt == CNT_W'(SCAN_DIV - 1)) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= w_blank ? 7'h7F : seg7(w_digit);
    end
  end

  assign disp_busy = (r_state == CONV);
  assign disp_seg  = r_seg;
  assign disp_an   = r_an;

endmodule

// File: tb/tb_res_disp.sv
// Bench for res_disp: directed and random loads checked against an arithmetic digit model.
module tb_res_disp;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] disp_high = 4'h0, disp_low = 4'h0;
  logic       disp_load = 1'b0, disp_dec = 1'b0, disp_blank = 1'b1;
  logic       disp_busy;
  logic [6:0] disp_seg;
  logic [3:0] disp_an;

  int checks = 0;
  int errors = 0;

  int   model_val = 0;
  logic model_dec = 1'b0;
  logic [6:0] frame_seg [4];
  logic       frame_ok;

  res_disp #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .disp_high(disp_high), .disp_low(disp_low),
    .disp_load(disp_load), .disp_dec(disp_dec), .disp_blank(disp_blank),
    .disp_busy(disp_busy), .disp_seg(disp_seg), .disp_an(disp_an)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] hex_seg(input int d);
    case (d)
      0: hex_seg = 7'h40; 1: hex_seg = 7'h79; 2: hex_seg = 7'h24; 3: hex_seg = 7'h30;
      4: hex_seg = 7'h19; 5: hex_seg = 7'h12; 6: hex_seg = 7'h02; 7: hex_seg = 7'h78;
      8: hex_seg = 7'h00; 9: hex_seg = 7'h10; 10: hex_seg = 7'h08; 11: hex_seg = 7'h03;
      12: hex_seg = 7'h46; 13: hex_seg = 7'h21; 14: hex_seg = 7'h06; default: hex_seg = 7'h0E;
    endcase
  endfunction

  // Expected pattern for digit position d from the model value, mode and live blank input.
  function automatic logic [6:0] exp_seg(input int d);
    int d0, d1, d2;
    bit b;
    if (model_dec) begin
      d0 = model_val % 10; d1 = (model_val / 10) % 10; d2 = model_val / 100;
    end else begin
      d0 = model_val % 16; d1 = model_val / 16; d2 = 0;
    end
    case (d)
      0: b = 0;
      1: b = model_dec ? (disp_blank && d2 == 0 && d1 == 0) : (disp_blank && d1 == 0);
      2: b = model_dec ? (disp_blank && d2 == 0) : 1;
      default: b = 1;
    endcase
    if (b) exp_seg = 7'h7F;
    else exp_seg = hex_seg(d == 0 ? d0 : (d == 1 ? d1 : d2));
  endfunction

  task automatic sample_frame();
    int zeros, idx;
    frame_ok = 1'b1;
    for (int d = 0; d < 4; d++) frame_seg[d] = 7'bx;
    for (int i = 0; i < 4 * SD; i++) begin
      @(negedge clk);
      zeros = 0; idx = 0;
      for (int b = 0; b < 4; b++) if (disp_an[b] == 1'b0) begin zeros++; idx = b; end
      if (zeros != 1) frame_ok = 1'b0;
      else frame_seg[idx] = disp_seg;
    end
  endtask

  task automatic do_load(input logic [7:0] v, input logic dec, output int busy_n);
    @(negedge clk);
    {disp_high, disp_low} = v;
    disp_dec  = dec;
    disp_load = 1'b1;
    @(negedge clk);
    disp_load = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 30; i++) begin
      if (!disp_busy) break;
      busy_n++;
      @(negedge clk);
    end
    model_val = int'(v);
    model_dec = dec;
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    int idx;
    repeat (3) @(negedge clk);
    checks++; if (disp_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", disp_busy); end
    checks++; if (disp_an !== 4'b1111) begin errors++; $display("FAIL rst_an got %b want 1111", disp_an); end
    checks++; if (disp_seg !== 7'h7F) begin errors++; $display("FAIL rst_seg got %h want 7f", disp_seg); end
    rst = 1'b0;
    for (int k = 1; k <= 4 * SD; k++) begin
      @(negedge clk);
      idx = ((k - 1) / SD) % 4;
      exp_an = ~(4'b0001 << idx);
      checks++;
      if (disp_an !== exp_an) begin errors++; $display("FAIL scan_an k=%0d got %b want %b", k, disp_an, exp_an); end
      checks++;
      if (disp_seg !== exp_seg(idx)) begin errors++; $display("FAIL scan_seg k=%0d got %h want %h", k, disp_seg, exp_seg(idx)); end
    end
    disp_blank = 1'b0;
    sample_frame();
    checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL rst_frame_an got bad one-hot want one-hot"); end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (frame_seg[d] !== (d < 2 ? 7'h40 : 7'h7F)) begin
        errors++; $display("FAIL rst_noblank d%0d got %h want %h", d, frame_seg[d], (d < 2 ? 7'h40 : 7'h7F));
      end
    end
    disp_blank = 1'b1;
  endtask

  task automatic test_directed();
    int n;
    logic [6:0] exp [4];
    logic [7:0] vals [5] = '{8'hFF, 8'hFF, 8'h07, 8'h64, 8'h05};
    logic       decs [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [27:0] pats [5] = '{{7'h7F, 7'h24, 7'h12, 7'h12}, {7'h7F, 7'h7F, 7'h0E, 7'h0E},
                              {7'h7F, 7'h7F, 7'h7F, 7'h78}, {7'h7F, 7'h79, 7'h40, 7'h40},
                              {7'h7F, 7'h7F, 7'h7F, 7'h12}};
    for (int t = 0; t < 5; t++) begin
      disp_blank = 1'b1;
      do_load(vals[t], decs[t], n);
      checks++; if (n != 8) begin errors++; $display("FAIL dir_busy t=%0d got %0d want 8", t, n); end
      sample_frame();
      for (int d = 0; d < 4; d++) exp[d] = pats[t][d*7 +: 7];
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (frame_seg[d] !== exp[d]) begin errors++; $display("FAIL dir t=%0d d%0d got %h want %h", t, d, frame_seg[d], exp[d]); end
      end
      if (t == 2) begin
        disp_blank = 1'b0;
        sample_frame();
        checks++;
        if (frame_seg[1] !== 7'h40) begin errors++; $display("FAIL live_blank d1 got %h want 40", frame_seg[1]); end
        disp_blank = 1'b1;
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, falls, idx;
    logic prev;
    logic dec;
    dec = 1'($urandom_range(0, 1));
    @(negedge clk);
    {disp_high, disp_low} = 8'h12;
    disp_dec  = dec;
    disp_load = 1'b1;
    @(negedge clk);
    {disp_high, disp_low} = 8'hFF;
    disp_dec = ~dec;
    n = 0; falls = 0; prev = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) disp_load = 1'b0;
      if (disp_busy) n++;
      if (prev && !disp_busy) falls++;
      prev = disp_busy;
      if (i == 4) begin
        idx = 0;
        for (int b = 0; b < 4; b++) if (disp_an[b] == 1'b0) idx = b;
        checks++;
        if (disp_seg !== exp_seg(idx)) begin errors++; $display("FAIL old_digits got %h want %h", disp_seg, exp_seg(idx)); end
      end
      @(negedge clk);
    end
    model_val = 8'h12;
    model_dec = dec;
    checks++; if (n != 8) begin errors++; $display("FAIL b2b_busy got %0d want 8", n); end
    checks++; if (falls != 1) begin errors++; $display("FAIL b2b_falls got %0d want 1", falls); end
    sample_frame();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (frame_seg[d] !== exp_seg(d)) begin errors++; $display("FAIL b2b d%0d got %h want %h", d, frame_seg[d], exp_seg(d)); end
    end
  endtask

  task automatic test_random();
    int n;
    logic [7:0] v;
    logic dec;
    for (int t = 0; t < 20; t++) begin
      v   = 8'($urandom_range(0, 255));
      dec = 1'($urandom_range(0, 1));
      disp_blank = 1'($urandom_range(0, 1));
      do_load(v, dec, n);
      checks++; if (n != 8) begin errors++; $display("FAIL rnd_busy v=%h got %0d want 8", v, n); end
      sample_frame();
      checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL rnd_an v=%h got bad one-hot want one-hot", v); end
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (frame_seg[d] !== exp_seg(d)) begin
          errors++; $display("FAIL rnd v=%h dec=%b d%0d got %h want %h", v, dec, d, frame_seg[d], exp_seg(d));
        end
      end
    end
    disp_blank = 1'b1;
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    {disp_high, disp_low} = 8'hFF;
    disp_dec  = 1'b1;
    disp_load = 1'b1;
    @(negedge clk);
    disp_load = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (disp_busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got %b want 1", disp_busy); end
    rst = 1'b1;
    #1;
    checks++; if (disp_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", disp_busy); end
    checks++; if (disp_an !== 4'b1111) begin errors++; $display("FAIL abort_an got %b want 1111", disp_an); end
    checks++; if (disp_seg !== 7'h7F) begin errors++; $display("FAIL abort_seg got %h want 7f", disp_seg); end
    @(negedge clk);
    rst = 1'b0;
    model_val = 0;
    model_dec = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (disp_busy !== 1'b0) begin errors++; $display("FAIL abort_post_busy got %b want 0", disp_busy); end
    disp_blank = 1'b0;
    sample_frame();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (frame_seg[d] !== exp_seg(d)) begin errors++; $display("FAIL abort d%0d got %h want %h", d, frame_seg[d], exp_seg(d)); end
    end
    disp_blank = 1'b1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
